core_run_controller: RTL and testbench

Run-control sequencer wrapped around the single-cycle RV32 core. It loads a program into instruction memory over a valid/ready stream, holds the core in reset while loading, releases it, and gates its clock-enable. It halts the core on ECALL/EBREAK, abort or watchdog, then reports the cause, halt PC and retired-instruction count. Instantiated at SoC top between the host/debug port, the instruction-memory write port and the core.

---
 rtl/core_run_controller.sv | 140 ++++++++++++++
 tb/tb_core_run_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_controller.sv
// Run-control sequencer for the single-cycle RV32 core: program load, reset/run/halt sequencing, halt reporting.
// Optional watchdog halt is compiled in with the CORE_WATCHDOG_EN macro.
module core_run_controller #(
  parameter int ADDR_W     = 8,
  parameter int MAX_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              loadValid,
  output logic              loadReady,
  input  logic [ADDR_W-1:0] loadAddr,
  input  logic [31:0]       loadData,
  input  logic              loadLast,
  output logic              imemWe,
  output logic [ADDR_W-1:0] imemAddr,
  output logic [31:0]       imemWData,
  input  logic [31:0]       corePc,
  input  logic [31:0]       coreInstr,
  output logic              coreReset,
  output logic              coreRun,
  output logic              busy,
  output logic              done,
  output logic [1:0]        haltCause,
  output logic [31:0]       haltPc,
  output logic [31:0]       retireCount
);

  // Load handshake: a beat transfers on any cycle where loadValid && loadReady.
  // loadReady depends only on state, never on loadValid.
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RST, S_RUN, S_HALT} state_e;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  state_e            state_q, state_d;
  logic              rst_cnt_q, rst_cnt_d;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic [1:0]        cause_q, cause_d;
  logic [31:0]       halt_pc_q, halt_pc_d;
  logic [31:0]       retire_q, retire_d;
  logic              accept, is_ecall, is_ebreak, wd_hit, stop, run_en;

`ifdef CORE_WATCHDOG_EN
  localparam logic [31:0] WD_LIMIT = 32'(MAX_CYCLES - 1);
  assign wd_hit = (retire_q == WD_LIMIT);
`else
  logic [31:0] unused_max_cycles;
  assign unused_max_cycles = 32'(MAX_CYCLES);
  assign wd_hit = 1'b0;
`endif

  assign loadReady = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_HALT);
  assign accept    = loadValid && loadReady;
  assign is_ecall  = (coreInstr == INSTR_ECALL);
  assign is_ebreak = (coreInstr == INSTR_EBREAK);
  // The halting instruction is suppressed in the same cycle it is fetched.
  assign stop      = (state_q == S_RUN) && (is_ecall || is_ebreak || abort || wd_hit);
  assign run_en    = (state_q == S_RUN) && !stop;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = 1'b0;
    cause_d   = cause_q;
    halt_pc_d = halt_pc_q;
    retire_d  = retire_q;
    if (run_en && (retire_q != 32'hFFFF_FFFF)) begin
      retire_d = retire_q + 32'd1;
    end
    case (state_q)
      S_IDLE, S_HALT: begin
        if (accept) begin
          state_d = S_LOAD;
        end else if (start) begin
          state_d   = S_RST;
          cause_d   = 2'b00;
          halt_pc_d = 32'd0;
          retire_d  = 32'd0;
        end
      end
      S_LOAD: begin
        if (accept && loadLast) state_d = S_IDLE;
      end
      S_RST: begin
        if (rst_cnt_q) state_d = S_RUN;
        else           rst_cnt_d = 1'b1;
      end
      S_RUN: begin
        if (stop) begin
          state_d   = S_HALT;
          halt_pc_d = corePc;
          if (is_ecall)       cause_d = 2'b01;
          else if (is_ebreak) cause_d = 2'b10;
          else                cause_d = 2'b11;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      cause_q      <= 2'b00;
      halt_pc_q    <= 32'd0;
      retire_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      imem_we_q <= accept;
      if (accept) begin
        imem_addr_q  <= loadAddr;
        imem_wdata_q <= loadData;
      end
      cause_q   <= cause_d;
      halt_pc_q <= halt_pc_d;
      retire_q  <= retire_d;
    end
  end

  // HALT keeps the core out of reset with its clock gated so its state stays inspectable.
  assign coreReset   = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_RST);
  assign coreRun     = run_en;
  assign busy        = (state_q == S_LOAD) || (state_q == S_RST) || (state_q == S_RUN);
  assign done        = (state_q == S_HALT);
  assign imemWe      = imem_we_q;
  assign imemAddr    = imem_addr_q;
  assign imemWData   = imem_wdata_q;
  assign haltCause   = cause_q;
  assign haltPc      = halt_pc_q;
  assign retireCount = retire_q;

endmodule

// File: tb/tb_core_run_controller.sv
// Directed bench for core_run_controller with a tiny core/memory model and an imem write scoreboard.
module tb_core_run_controller;
  localparam int          ADDR_W   = 8;
  localparam logic [31:0] JAL_SELF = 32'h0000_006F;
  localparam logic [31:0] ECALL    = 32'h0000_0073;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic              clk, reset, start, abort;
  logic              loadValid, loadReady, loadLast;
  logic [ADDR_W-1:0] loadAddr, imemAddr;
  logic [31:0]       loadData, imemWData;
  logic              imemWe, coreReset, coreRun, busy, done;
  logic [31:0]       corePc, coreInstr, haltPc, retireCount;
  logic [1:0]        haltCause;

  int checks   = 0;
  int failures = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] sb_e;
  logic [31:0]        mem [0:255];
  logic [31:0]        pc_q;

  core_run_controller #(.ADDR_W(ADDR_W), .MAX_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .loadValid(loadValid), .loadReady(loadReady), .loadAddr(loadAddr),
    .loadData(loadData), .loadLast(loadLast),
    .imemWe(imemWe), .imemAddr(imemAddr), .imemWData(imemWData),
    .corePc(corePc), .coreInstr(coreInstr),
    .coreReset(coreReset), .coreRun(coreRun), .busy(busy), .done(done),
    .haltCause(haltCause), .haltPc(haltPc), .retireCount(retireCount)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  // Core and instruction memory stand-in: one instruction per enabled cycle, JAL_SELF loops.
  assign corePc    = pc_q;
  assign coreInstr = mem[pc_q[9:2]];
  always @(posedge clk) begin
    if (imemWe) mem[imemAddr] <= imemWData;
    if (coreReset)    pc_q <= 32'd0;
    else if (coreRun) pc_q <= (coreInstr == JAL_SELF) ? pc_q : pc_q + 32'd4;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write on the imem port must match the next accepted beat.
  always @(negedge clk) begin
    #2;
    if (reset && imemWe) begin
      if (exp_q.size() == 0) begin
        check("imem_unexpected_write", 32'(imemWe), 32'd0);
      end else begin
        sb_e = exp_q.pop_front();
        check("imem_addr", 32'(imemAddr), 32'(sb_e[ADDR_W+31:32]));
        check("imem_data", imemWData, sb_e[31:0]);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic last);
    check("load_ready", 32'(loadReady), 32'd1);
    loadValid = 1'b1;
    loadAddr  = a;
    loadData  = d;
    loadLast  = last;
    exp_q.push_back({a, d});
    tick();
    loadValid = 1'b0;
    loadLast  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    loadValid = 1'b0; loadAddr = '0; loadData = 32'd0; loadLast = 1'b0;
    #2;
    check("rst_core_reset", 32'(coreReset), 32'd1);
    check("rst_core_run", 32'(coreRun), 32'd0);
    check("rst_imem_we", 32'(imemWe), 32'd0);
    check("rst_imem_addr", 32'(imemAddr), 32'd0);
    check("rst_imem_wdata", imemWData, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cause", 32'(haltCause), 32'd0);
    check("rst_halt_pc", haltPc, 32'd0);
    check("rst_retire", retireCount, 32'd0);
    check("rst_load_ready", 32'(loadReady), 32'd1);
    // A beat offered during reset must not be written.
    loadValid = 1'b1; loadAddr = 8'd5; loadData = 32'hDEAD_BEEF;
    tick();
    check("rst_beat_dropped", 32'(imemWe), 32'd0);
    loadValid = 1'b0;
    reset = 1'b1;
    tick();

    // Three-beat program load, ECALL at PC 8.
    send(8'd0, 32'h0050_0093, 1'b0);
    check("load_busy", 32'(busy), 32'd1);
    check("load_core_reset0", 32'(coreReset), 32'd1);
    send(8'd1, 32'h0010_8113, 1'b0);
    check("load_core_reset1", 32'(coreReset), 32'd1);
    send(8'd2, ECALL, 1'b1);
    check("load_idle_busy", 32'(busy), 32'd0);
    check("load_idle_core_reset", 32'(coreReset), 32'd1);

    pulse_start();
    check("rst1_core_reset", 32'(coreReset), 32'd1);
    check("rst1_busy", 32'(busy), 32'd1);
    check("rst1_core_run", 32'(coreRun), 32'd0);
    tick();
    check("rst2_core_reset", 32'(coreReset), 32'd1);
    tick();
    check("run1_core_reset", 32'(coreReset), 32'd0);
    check("run1_core_run", 32'(coreRun), 32'd1);
    check("run1_pc", corePc, 32'd0);
    tick();
    check("run2_core_run", 32'(coreRun), 32'd1);
    tick();
    check("ecall_cycle_run", 32'(coreRun), 32'd0);
    check("ecall_cycle_done", 32'(done), 32'd0);
    tick();
    check("ecall_done", 32'(done), 32'd1);
    check("ecall_cause", 32'(haltCause), 32'd1);
    check("ecall_halt_pc", haltPc, 32'h0000_0008);
    check("ecall_retire", retireCount, 32'd2);
    check("ecall_busy", 32'(busy), 32'd0);
    check("halt_core_reset", 32'(coreReset), 32'd0);
    tick();
    check("halt_frozen_retire", retireCount, 32'd2);

    // Loop program loaded from HALT; first beat clears done.
    send(8'd0, JAL_SELF, 1'b0);
    check("halt_load_done", 32'(done), 32'd0);
    check("halt_load_busy", 32'(busy), 32'd1);
    send(8'd1, JAL_SELF, 1'b1);
    check("halt_load_idle", 32'(busy), 32'd0);

    // start and loadValid together in IDLE: beat wins, start ignored in LOAD.
    start = 1'b1;
    send(8'd0, EBREAK, 1'b0);
    check("combo_busy", 32'(busy), 32'd1);
    check("combo_core_reset", 32'(coreReset), 32'd1);
    tick();
    check("combo_start_ignored", 32'(coreReset), 32'd1);
    check("combo_still_load", 32'(busy), 32'd1);
    start = 1'b0;
    send(8'd1, JAL_SELF, 1'b1);
    check("combo_idle", 32'(busy), 32'd0);
    pulse_start();
    tick();
    tick();
    check("ebreak_core_reset", 32'(coreReset), 32'd0);
    check("ebreak_cycle_run", 32'(coreRun), 32'd0);
    tick();
    check("ebreak_done", 32'(done), 32'd1);
    check("ebreak_cause", 32'(haltCause), 32'd2);
    check("ebreak_retire", retireCount, 32'd0);
    check("ebreak_halt_pc", haltPc, 32'd0);

    // Infinite loop with abort after 10 RUN cycles; abort during RST is ignored.
    send(8'd0, JAL_SELF, 1'b0);
    send(8'd1, JAL_SELF, 1'b1);
    pulse_start();
    check("rerun_cause_clear", 32'(haltCause), 32'd0);
    check("rerun_retire_clear", retireCount, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check("abort_rst_ignored", 32'(coreRun), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    check("abort_pre_retire", retireCount, 32'd10);
    abort = 1'b1;
    #1;
    check("abort_cycle_run", 32'(coreRun), 32'd0);
    tick();
    abort = 1'b0;
    check("abort_done", 32'(done), 32'd1);
    check("abort_cause", 32'(haltCause), 32'd3);
    check("abort_retire", retireCount, 32'd10);

`ifdef CORE_WATCHDOG_EN
    begin
      int n;
      pulse_start();
      n = 0;
      while (!done && n < 60) begin
        tick();
        n++;
      end
      check("wd_timeout", 32'(done), 32'd1);
      check("wd_cause", 32'(haltCause), 32'd3);
      check("wd_retire", retireCount, 32'd15);
    end
`endif

    // Reset dropped mid-RUN acts without a clock edge.
    pulse_start();
    tick();
    tick();
    tick();
    check("mid_run_active", 32'(coreRun), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("async_core_reset", 32'(coreReset), 32'd1);
    check("async_core_run", 32'(coreRun), 32'd0);
    check("async_retire", retireCount, 32'd0);
    check("async_cause", 32'(haltCause), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_idle_busy", 32'(busy), 32'd0);
    check("post_rst_done", 32'(done), 32'd0);
    check("post_rst_ready", 32'(loadReady), 32'd1);
    check("post_rst_halt_pc", haltPc, 32'd0);

    // Reset during LOAD drops a pending write.
    loadValid = 1'b1; loadAddr = 8'd9; loadData = 32'h0000_1234; loadLast = 1'b0;
    @(posedge clk);
    #1;
    check("pending_we", 32'(imemWe), 32'd1);
    loadValid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("pending_we_dropped", 32'(imemWe), 32'd0);
    check("load_rst_core_reset", 32'(coreReset), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check("load_rst_idle", 32'(busy), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
